// File: rtl/instrmem_loader_if.sv
// rtl/instrmem_loader_if.sv - host byte stream, load control and CPU fetch port bundle
interface instrmem_loader_if #(
   parameter int DEPTH = 64
);
   localparam int AW = $clog2(DEPTH);

   logic          load_start;
   logic          load_end;
   logic [7:0]    byte_in;
   logic          byte_valid;
   logic          byte_ready;
   logic [31:0]   addr;
   logic [31:0]   instr;
   logic          loading;
   logic          load_done;
   logic          load_error;
   logic [AW:0]   word_count;

   modport master (
      output load_start, load_end, byte_in, byte_valid, addr,
      input  byte_ready, instr, loading, load_done, load_error, word_count
   );

   modport slave (
      input  load_start, load_end, byte_in, byte_valid, addr,
      output byte_ready, instr, loading, load_done, load_error, word_count
   );
endinterface

// File: rtl/instrmem_loader.sv
// rtl/instrmem_loader.sv - byte-stream program loader into a word-wide instruction RAM
// Assembles little-endian words and holds the CPU off until the load completes.
module instrmem_loader #(
   parameter int DEPTH = 64
) (
   input  logic              clk,
   input  logic              reset_n,
   instrmem_loader_if.slave  bus
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] WC_FULL = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

   state_t         state_q, state_d;
   logic [AW:0]    word_count_q, word_count_d;
   logic [1:0]     byte_idx_q, byte_idx_d;
   logic [23:0]    shift_q, shift_d;
   logic           load_error_q, load_error_d;
   logic           word_we;
   logic [AW-1:0]  rd_idx;
   logic           rd_hit;

   logic [31:0]    mem [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         word_count_q <= '0;
         byte_idx_q   <= '0;
         shift_q      <= '0;
         load_error_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
         byte_idx_q   <= byte_idx_d;
         shift_q      <= shift_d;
         load_error_q <= load_error_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      word_count_d = word_count_q;
      byte_idx_d   = byte_idx_q;
      shift_d      = shift_q;
      load_error_d = load_error_q;
      word_we      = 1'b0;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.load_start) begin
               state_d      = S_LOAD;
               word_count_d = '0;
               byte_idx_d   = '0;
               load_error_d = 1'b0;
            end
         end
         S_LOAD: begin
            if (bus.load_start) begin
               // Restart wins over any byte offered in the same cycle.
               word_count_d = '0;
               byte_idx_d   = '0;
               load_error_d = 1'b0;
            end else begin
               if (bus.byte_valid) begin
                  byte_idx_d = byte_idx_q + 2'd1;
                  case (byte_idx_q)
                     2'd0:    shift_d[7:0]   = bus.byte_in;
                     2'd1:    shift_d[15:8]  = bus.byte_in;
                     2'd2:    shift_d[23:16] = bus.byte_in;
                     default: begin
                        word_we      = 1'b1;
                        word_count_d = word_count_q + (AW+1)'(1);
                     end
                  endcase
               end
               // load_end is judged against the post-accept byte index and count.
               if (word_count_d == WC_FULL) begin
                  state_d = S_DONE;
               end else if (bus.load_end) begin
                  state_d = S_DONE;
                  if (byte_idx_d != 2'd0) load_error_d = 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      bus.byte_ready = (state_q == S_LOAD);
      bus.loading    = (state_q == S_LOAD);
      bus.load_done  = (state_q == S_DONE);
      bus.load_error = load_error_q;
      bus.word_count = word_count_q;
   end

   always_ff @(posedge clk) begin
      if (word_we) mem[word_count_q[AW-1:0]] <= {bus.byte_in, shift_q};
   end

   // Unwritten RAM is never reset, so reads past word_count are masked to zero.
   always_comb begin
      rd_idx    = bus.addr[AW+1:2];
      rd_hit    = (state_q != S_LOAD) && (bus.addr[31:AW+2] == '0)
                  && ({1'b0, rd_idx} < word_count_q);
      bus.instr = rd_hit ? mem[rd_idx] : 32'h0;
   end
endmodule

// File: tb/tb_instrmem_loader.sv
// tb/tb_instrmem_loader.sv - scoreboard bench for instrmem_loader
module tb_instrmem_loader;
   localparam int DEPTH = 64;

   localparam int K_INSTR = 0;
   localparam int K_DONE  = 1;
   localparam int K_LOAD  = 2;
   localparam int K_ERR   = 3;
   localparam int K_WC    = 4;
   localparam int K_RDY   = 5;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
   } exp_t;

   logic clk;
   logic reset_n;
   logic chk_req;
   int   n_cmp;
   int   n_bad;
   exp_t sb[$];

   instrmem_loader_if #(.DEPTH(DEPTH)) bus();

   instrmem_loader #(.DEPTH(DEPTH)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (chk_req) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_underflow: got check request, required queued entry");
         end else begin
            exp_t        e;
            logic [31:0] act;
            e = sb.pop_front();
            case (e.kind)
               K_INSTR: act = bus.instr;
               K_DONE:  act = {31'h0, bus.load_done};
               K_LOAD:  act = {31'h0, bus.loading};
               K_ERR:   act = {31'h0, bus.load_error};
               K_WC:    act = 32'(bus.word_count);
               default: act = {31'h0, bus.byte_ready};
            endcase
            if (act !== e.exp) begin
               n_bad++;
               $display("FAIL %s: got %h, required %h", e.name, act, e.exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(input string name, input int kind, input logic [31:0] a,
                           input logic [31:0] exp);
      exp_t e;
      e.name = name;
      e.kind = kind;
      e.exp  = exp;
      bus.addr = a;
      sb.push_back(e);
      chk_req = 1'b1;
      tick();
      chk_req = 1'b0;
   endtask

   task automatic expect_s(input string name, input int kind, input logic [31:0] exp);
      expect_v(name, kind, 32'h0, exp);
   endtask

   task automatic pulse_start();
      bus.load_start = 1'b1;
      tick();
      bus.load_start = 1'b0;
   endtask

   task automatic pulse_end();
      bus.load_end = 1'b1;
      tick();
      bus.load_end = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic with_end);
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      bus.load_end   = with_end;
      tick();
      bus.byte_valid = 1'b0;
      bus.load_end   = 1'b0;
   endtask

   initial begin
      logic [7:0] prog1 [8];
      prog1 = '{8'hE3, 8'h00, 8'h10, 8'h20, 8'h00, 8'hF0, 8'h10, 8'hAC};
      n_cmp = 0;
      n_bad = 0;
      chk_req = 1'b0;
      reset_n = 1'b0;
      bus.load_start = 1'b0;
      bus.load_end   = 1'b0;
      bus.byte_in    = 8'h0;
      bus.byte_valid = 1'b0;
      bus.addr       = 32'h0;
      tick();
      tick();

      // Held in reset
      expect_s("rst_loading", K_LOAD, 32'd0);
      expect_s("rst_done",    K_DONE, 32'd0);
      expect_s("rst_ready",   K_RDY,  32'd0);
      expect_s("rst_err",     K_ERR,  32'd0);
      expect_s("rst_wc",      K_WC,   32'd0);
      expect_v("rst_instr",   K_INSTR, 32'h0, 32'h0);
      reset_n = 1'b1;
      tick();

      // load_end while idle is ignored
      pulse_end();
      expect_s("idle_end_done", K_DONE, 32'd0);

      // Two-word program
      pulse_start();
      expect_s("l1_loading", K_LOAD, 32'd1);
      expect_s("l1_ready",   K_RDY,  32'd1);
      for (int i = 0; i < 8; i++) send_byte(prog1[i], 1'b0);
      pulse_end();
      expect_s("l1_done",  K_DONE, 32'd1);
      expect_s("l1_wc",    K_WC,   32'd2);
      expect_s("l1_err",   K_ERR,  32'd0);
      expect_s("l1_ready_off", K_RDY, 32'd0);
      expect_v("l1_i0",  K_INSTR, 32'h0, 32'h201000E3);
      expect_v("l1_i4",  K_INSTR, 32'h4, 32'hAC10F000);
      expect_v("l1_i8",  K_INSTR, 32'h8, 32'h0);
      expect_v("l1_i1_unaligned", K_INSTR, 32'h1, 32'h201000E3);
      expect_v("l1_i7_unaligned", K_INSTR, 32'h7, 32'hAC10F000);

      // Five bytes then load_end: partial word discarded, error flagged
      pulse_start();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      send_byte(8'h33, 1'b0);
      send_byte(8'h44, 1'b0);
      send_byte(8'h55, 1'b0);
      expect_v("l2_instr_masked_loading", K_INSTR, 32'h0, 32'h0);
      pulse_end();
      expect_s("l2_err",  K_ERR,  32'd1);
      expect_s("l2_wc",   K_WC,   32'd1);
      expect_s("l2_done", K_DONE, 32'd1);
      expect_v("l2_i0", K_INSTR, 32'h0, 32'h44332211);
      expect_v("l2_i4", K_INSTR, 32'h4, 32'h0);

      // load_end together with the 4th byte
      pulse_start();
      expect_s("l3_err_cleared", K_ERR, 32'd0);
      send_byte(8'h01, 1'b0);
      send_byte(8'h02, 1'b0);
      send_byte(8'h03, 1'b0);
      send_byte(8'h04, 1'b1);
      expect_s("l3_wc",   K_WC,   32'd1);
      expect_s("l3_err",  K_ERR,  32'd0);
      expect_s("l3_done", K_DONE, 32'd1);
      expect_v("l3_i0", K_INSTR, 32'h0, 32'h04030201);

      // Restart mid-load; the byte offered with load_start is dropped
      pulse_start();
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b0);
      bus.byte_in    = 8'hCC;
      bus.byte_valid = 1'b1;
      pulse_start();
      bus.byte_valid = 1'b0;
      send_byte(8'h10, 1'b0);
      send_byte(8'h20, 1'b0);
      send_byte(8'h30, 1'b0);
      send_byte(8'h40, 1'b0);
      pulse_end();
      expect_s("l4_wc",  K_WC,  32'd1);
      expect_s("l4_err", K_ERR, 32'd0);
      expect_v("l4_i0", K_INSTR, 32'h0, 32'h40302010);

      // Fill the whole RAM at one byte per cycle
      pulse_start();
      for (int i = 0; i < 4 * DEPTH; i++) send_byte(8'(i), 1'b0);
      expect_s("fill_loading", K_LOAD, 32'd0);
      expect_s("fill_done",    K_DONE, 32'd1);
      expect_s("fill_ready",   K_RDY,  32'd0);
      for (int i = 0; i < 4; i++) send_byte(8'h5A, 1'b0);
      pulse_end();
      expect_s("fill_wc",  K_WC,  32'(DEPTH));
      expect_s("fill_err", K_ERR, 32'd0);
      expect_v("fill_i0",    K_INSTR, 32'h0,      32'h03020100);
      expect_v("fill_i80",   K_INSTR, 32'h80,     32'h83828180);
      expect_v("fill_ifc",   K_INSTR, 32'hFC,     32'hFFFEFDFC);
      expect_v("fill_iff",   K_INSTR, 32'hFF,     32'hFFFEFDFC);
      expect_v("fill_i100",  K_INSTR, 32'h100,    32'h0);
      expect_v("fill_if000", K_INSTR, 32'hF000,   32'h0);

      // New load from DONE blanks fetches
      pulse_start();
      expect_s("reload_loading", K_LOAD, 32'd1);
      expect_v("reload_i0",  K_INSTR, 32'h0,  32'h0);
      expect_v("reload_ifc", K_INSTR, 32'hFC, 32'h0);

      // Asynchronous abort after six bytes
      for (int i = 0; i < 6; i++) send_byte(8'hE0 + 8'(i), 1'b0);
      reset_n = 1'b0;
      expect_s("abort_loading", K_LOAD, 32'd0);
      expect_s("abort_ready",   K_RDY,  32'd0);
      expect_s("abort_wc",      K_WC,   32'd0);
      expect_s("abort_done",    K_DONE, 32'd0);
      expect_v("abort_i0", K_INSTR, 32'h0, 32'h0);
      reset_n = 1'b1;
      tick();
      tick();
      expect_s("post_rst_loading", K_LOAD, 32'd0);
      expect_v("post_rst_i0", K_INSTR, 32'h0, 32'h0);
      pulse_start();
      send_byte(8'h78, 1'b0);
      send_byte(8'h56, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h12, 1'b0);
      pulse_end();
      expect_s("post_rst_wc", K_WC, 32'd1);
      expect_v("post_rst_instr", K_INSTR, 32'h0, 32'h12345678);

      tick();
      tick();
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/instrmem_loader.md
INSTRMEM_LOADER -- requirements
Module: instrmem_loader

Interface
REQ-001 Parameter DEPTH, default 64, instruction RAM depth in 32-bit words (power of two, 4..256).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 load_start  input  1  one-cycle pulse; begin a new program load.
REQ-005 load_end  input  1  one-cycle pulse; host signals end of program stream.
REQ-006 byte_in  input  8  program byte from host loader.
REQ-007 byte_valid  input  1  byte_in is valid this cycle.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 addr  input  32  CPU instruction fetch byte address.
REQ-010 instr  output  32  instruction word at addr (combinational read).
REQ-011 loading  output  1  high while in LOAD state.
REQ-012 load_done  output  1  high in DONE state; the CPU is released from reset by this signal.
REQ-013 load_error  output  1  sticky: partial word at load_end.
REQ-014 word_count  output  log2(DEPTH)+1  number of complete words written.

Function
REQ-015 The FSM SHALL have three states: IDLE, LOAD, DONE.
REQ-016 IDLE/DONE + load_start -> LOAD; on entry, word_count=0, byte index=0, load_error=0.
REQ-017 load_start while in LOAD SHALL restart the load (same clearing as REQ-016); any byte presented that cycle is dropped.
REQ-018 In LOAD, byte_ready SHALL be 1; in IDLE/DONE, byte_ready SHALL be 0.
REQ-019 A byte is accepted on any edge where byte_valid && byte_ready; otherwise byte_in is ignored.
REQ-020 Bytes SHALL assemble little-endian: the 1st accepted byte goes to bits[7:0] and the 4th to bits[31:24].
REQ-021 On the edge accepting the 4th byte, the word SHALL be written to RAM[word_count], word_count increments, and byte index returns to 0 (zero-bubble; back-to-back bytes at 1/cycle are sustained).
REQ-022 When word_count reaches DEPTH, the FSM SHALL go to DONE on that same edge; no further bytes are accepted.
REQ-023 load_end in LOAD -> DONE; if byte index != 0 at that point, load_error=1 and the partial word SHALL be discarded.
REQ-024 If load_end coincides with an accepted byte, the byte SHALL be accepted first, then REQ-023 is evaluated against the updated byte index and word_count.
REQ-025 load_end in IDLE/DONE SHALL be ignored.
REQ-026 instr SHALL be RAM[addr[log2(DEPTH)+1:2]] when loading=0, addr bits above the index are 0, and the index < word_count; otherwise instr=0.
REQ-027 addr[1:0] SHALL be ignored; fetches are word aligned.
REQ-028 RAM contents are not reset; words at index >= word_count are masked to 0 by REQ-026.

Reset
REQ-029 While reset_n=0: FSM=IDLE, byte_ready=0, loading=0, load_done=0, load_error=0, word_count=0, byte index=0, and instr=0 for every addr.
REQ-030 Reset asserted mid-load SHALL abort the load immediately (asynchronously); after release the FSM stays in IDLE until load_start.

Verification
REQ-031 Load 2 words: bytes E3,00,10,20,00,F0,10,AC, then load_end -> load_done=1, word_count=2, instr@0x0=0x201000E3, instr@0x4=0xAC10F000, instr@0x8=0.
REQ-032 5 bytes then load_end -> load_error=1, word_count=1, instr@0x4=0, DONE state.
REQ-033 Stream 4*DEPTH bytes at 1/cycle without load_end -> DONE on the last byte's edge, byte_ready=0 afterwards, and extra bytes are ignored.
REQ-034 load_end on the same cycle as the 4th byte -> word written, word_count=1, load_error=0.
REQ-035 reset_n pulled low after 6 bytes -> all outputs zero immediately; instr@0x0=0 after release; a new load_start works normally.
REQ-036 In DONE, addr=0x100 (with DEPTH=64) and addr=0x0000F000 -> instr=0; load_start -> loading=1 and instr=0 for all addr.
